ram_sync_reader: RTL and testbench
==================================

# ram_sync_reader

Read-side initiator for the 32×32 `ram_sync` memory. On a `start` pulse it reads `count` consecutive words beginning at `base_addr`, with address wrap-around. It absorbs the RAM's one-cycle synchronous read latency and streams the words out on a valid/ready interface that supports backpressure. It sits between `ram_sync` and any consumer that needs a block readback, such as a checker, a UART transmitter or a CPU fetch path.

## Interface
Parameters:
- `ADDR_W`, 5: RAM address width; depth is 2^ADDR_W = 32.
- `DATA_W`, 32: word width.
- `DEPTH`, 2: output buffer entries. Must be ≥ 2 for full throughput.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first address; sampled with `start`.
- `count`  in  ADDR_W+1  words to read, 0..32; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the transfer is finished.
- `mem_address`  out  ADDR_W  to `ram_sync.address`.
- `mem_writeOn`  out  1  to `ram_sync.writeOn`; constant 0.
- `mem_data_out`  in  DATA_W  from `ram_sync.data_out`.
- `out_data`  out  DATA_W  head word of the buffer.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_valid && out_ready`.

## Operation
- FSM states:
  - IDLE → READ on `start` with `count`≠0.
  - IDLE → FINISH on `start` with `count`=0 (no RAM access).
  - READ → DRAIN when the last address has been issued.
  - DRAIN → FINISH when the final word is accepted.
  - FINISH → IDLE unconditionally; `done`=1 only in FINISH.
- Issue rule, READ only: issue a read in the current cycle iff `fifo_count + in_flight − pop < DEPTH`, where `pop = out_valid && out_ready`.
  - On issue, `mem_address` advances by 1 at the next edge, modulo 32 (31 → 0 wrap).
  - The remaining-count register decrements on each issue.
- `in_flight` is a 1-bit flag meaning "an address was presented last cycle". Its data is pushed into the buffer at the next edge.
- The buffer is a FIFO with `DEPTH` entries. It pushes and pops in the same cycle without loss. It never overflows; overflow is a design error and must be asserted in simulation.
- `start` while `busy` is ignored. `base_addr` and `count` changes while `busy` have no effect.
- `mem_writeOn` is 0 in every cycle, including during reset.
- Reset (`rst_n`=0 at an edge, at any point):
  - state → IDLE; buffer emptied; `in_flight` → 0.
  - Words in flight are discarded; no `done` is produced for the aborted transfer.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `mem_address`=0, `mem_writeOn`=0.
- `start` accepted at edge k: `busy`=1 and `mem_address`=`base_addr` during cycle k+1.
- RAM captures at edge k+1; the word enters the buffer at edge k+2; `out_valid`=1 from cycle k+3. First-word latency is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle. N words finish their last transfer in cycle k+N+2; `done` is in cycle k+N+3; `busy` falls in the same cycle as `done`.
- With `count`=0: `done` is in cycle k+1; `busy` never rises; `mem_address` is unchanged.
- `out_valid` does not drop, and `out_data` does not change, while `out_valid && !out_ready`.
- A new `start` may be accepted in the cycle after `done`.

## Structure
- Package `ram_pkg`:
  - `ADDR_W`=5 and `DATA_W`=32 constants, shared with `ram_sync`.
  - FSM state encoding IDLE/READ/DRAIN/FINISH.
- Sub-module `sync_fifo2`: parameterised (`DATA_W`, `DEPTH`) synchronous FIFO.
  - Ports: `push`, `pop`, `din`, `dout`, `count`, `empty`.
  - Same clock and reset style as this block.
- Top level: FSM, address counter, remaining counter, `in_flight` flag, issue logic.

## Test plan
- RAM preloaded with mem[i] = 32'hA000_0000+i; `start`, `base_addr`=0, `count`=5, `out_ready`=1 → words A000_0000..A000_0004 in consecutive cycles. First `out_valid` at k+3; `done` at k+8; `mem_writeOn`=0 throughout.
- Wrap: `base_addr`=30, `count`=4 → addresses 30, 31, 0, 1; data A000_001E, A000_001F, A000_0000, A000_0001.
- Backpressure: `count`=6 with `out_ready` toggling 1,0,0,1,… → all 6 words delivered in order with no duplicates; `out_data` stable while stalled; the FIFO overflow assertion never fires.
- `count`=32 from base 0 → full-memory sweep of 32 words; `done` is a single cycle; `start` pulsed mid-transfer is ignored.
- `count`=0 → `done` at k+1, no address change, `out_valid` stays 0.
- `rst_n` low for 1 cycle after the 2nd word of a `count`=8 read → next cycle shows reset values; no further words and no `done`. A following `start` (base 3, `count`=2) returns A000_0003 and A000_0004 correctly.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the 32x32 ram_sync memory and the reader FSM encoding.
package ram_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/ram_sync_reader_if.sv
// Valid/ready word stream leaving the reader.
interface ram_sync_reader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_fifo2.sv
// Small synchronous FIFO; simultaneous push and pop are lossless, even when full.
module sync_fifo2 #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      assert (!(push && !pop && count == CW'(DEPTH))) else $error("sync_fifo2: overflow");
      assert (!(pop && empty)) else $error("sync_fifo2: underflow");
    end
  end
endmodule

// File: rtl/ram_sync_reader.sv
// Block reader for ram_sync: issues count sequential reads (wrapping) and streams
// the words out, throttling issue so buffered plus in-flight words never exceed DEPTH.
module ram_sync_reader #(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_writeOn,
  input  logic [DATA_W-1:0] mem_data_out,
  ram_sync_reader_if.master strm
);
  import ram_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  state_t          state;
  logic [ADDR_W:0] remaining;
  logic            in_flight;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            pop;
  logic            issue;

  assign mem_writeOn    = 1'b0;
  assign strm.out_valid = !fifo_empty;
  assign pop            = strm.out_valid && strm.out_ready;

  // Written as add-compare so a pop never underflows the occupancy sum.
  assign issue = (state == READ) &&
                 (({1'b0, fifo_count} + (CW+1)'(in_flight)) < ((CW+1)'(DEPTH) + (CW+1)'(pop)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_address <= '0;
      remaining   <= '0;
      in_flight   <= 1'b0;
    end else begin
      in_flight <= issue;
      done      <= 1'b0;
      if (issue) begin
        mem_address <= mem_address + 1'b1;
        remaining   <= remaining - 1'b1;
      end
      unique case (state)
        IDLE: if (start) begin
          if (count == '0) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state       <= READ;
            busy        <= 1'b1;
            mem_address <= base_addr;
            remaining   <= count;
          end
        end
        READ:  if (issue && remaining == (ADDR_W+1)'(1)) state <= DRAIN;
        DRAIN: if (pop && !in_flight && fifo_count == CW'(1)) begin
          state <= FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        FINISH: state <= IDLE;
      endcase
    end
  end

  sync_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_flight),
    .pop   (pop),
    .din   (mem_data_out),
    .dout  (strm.out_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_ram_sync_reader.sv
// Bench for ram_sync_reader: table of block reads plus random runs, checked
// against a queue of expected words and the cycle-level latency rules.
module tb_ram_sync_reader;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, mem_writeOn;
  logic [4:0]  base_addr, mem_address;
  logic [5:0]  count;
  logic [31:0] mem_data_out;
  logic [31:0] ram [32];
  int          nchecks = 0, nfail = 0;

  ram_sync_reader_if #(.DATA_W(32)) strm ();

  ram_sync_reader #(.ADDR_W(5), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_writeOn(mem_writeOn),
    .mem_data_out(mem_data_out), .strm(strm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data_out <= ram[mem_address];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    nchecks++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) chk("mem_writeOn", mem_writeOn, 0);

  function automatic logic rdy(input int mode, input int lat);
    case (mode)
      0:       return 1'b1;
      1:       return ((lat - 1) % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // exp_done < 0: done latency not checked (ready not held high).
  task automatic run_xfer(input logic [4:0] b, input logic [5:0] n, input int mode,
                          input int exp_done, input bit mid);
    logic [31:0] expq [$];
    logic [31:0] prev_d;
    logic [4:0]  addr0;
    bit          seen_done, prev_stall;
    int          lat, first_v;
    for (int i = 0; i < n; i++) expq.push_back(ram[5'(int'(b) + i)]);
    addr0 = mem_address;
    start = 1'b1; base_addr = b; count = n; strm.out_ready = rdy(mode, 0);
    @(posedge clk); #1;
    base_addr = 5'($urandom); count = 6'($urandom);
    seen_done = 0; prev_stall = 0; first_v = -1; prev_d = '0;
    for (lat = 1; lat <= 200; lat++) begin
      strm.out_ready = rdy(mode, lat);
      start = mid && (lat == 10);
      @(negedge clk);
      if (lat == 1) begin
        chk("busy_after_start", busy, n != 0);
        chk("addr_after_start", mem_address, (n != 0) ? b : addr0);
      end
      if (strm.out_valid && first_v < 0) begin
        first_v = lat;
        chk("first_valid_lat", lat, 3);
      end
      if (prev_stall) begin
        chk("stall_valid", strm.out_valid, 1);
        chk("stall_data", strm.out_data, prev_d);
      end
      if (strm.out_valid && strm.out_ready) begin
        if (expq.size() == 0) chk("extra_word", strm.out_data, 0);
        else chk("word", strm.out_data, expq.pop_front());
      end
      prev_stall = strm.out_valid && !strm.out_ready;
      prev_d     = strm.out_data;
      if (done) begin
        if (exp_done >= 0) chk("done_lat", lat, exp_done);
        chk("words_left", expq.size(), 0);
        chk("busy_at_done", busy, 0);
        seen_done = 1;
      end else if (n != 0) chk("busy_during", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
      if (seen_done) break;
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    if (n == 0) chk("no_valid_for_zero", first_v, -1);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_after_done", busy, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0] base;
    logic [5:0] cnt;
    int         mode;
    int         exp_done;
    bit         mid;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int   pops;
    tbl[0] = '{5'd0,  6'd5,  0, 8,  1'b0};
    tbl[1] = '{5'd30, 6'd4,  0, 7,  1'b0};
    tbl[2] = '{5'd0,  6'd6,  1, -1, 1'b0};
    tbl[3] = '{5'd0,  6'd32, 0, 35, 1'b1};
    tbl[4] = '{5'd9,  6'd0,  0, 1,  1'b0};
    tbl[5] = '{5'd31, 6'd1,  0, 4,  1'b0};
    for (int i = 0; i < 32; i++) ram[i] = 32'hA000_0000 + i;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; strm.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", strm.out_valid, 0);
    chk("rst_data", strm.out_data, 0);
    chk("rst_addr", mem_address, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++)
      run_xfer(tbl[t].base, tbl[t].cnt, tbl[t].mode, tbl[t].exp_done, tbl[t].mid);

    // Reset after the second word of an 8-word read.
    start = 1'b1; base_addr = 5'd0; count = 6'd8; strm.out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pops = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (strm.out_valid && strm.out_ready) begin
        chk("pre_reset_word", strm.out_data, 32'hA000_0000 + pops);
        pops++;
      end
      @(posedge clk); #1;
    end
    chk("pre_reset_pops", pops, 2);
    rst_n = 1'b0; strm.out_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; strm.out_ready = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", strm.out_valid, 0);
    chk("abort_data", strm.out_data, 0);
    chk("abort_addr", mem_address, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_quiet_valid", strm.out_valid, 0);
      chk("abort_quiet_done", done, 0);
    end
    @(posedge clk); #1;
    run_xfer(5'd3, 6'd2, 0, 5, 1'b0);

    for (int r = 0; r < 3; r++) begin
      logic [5:0] n;
      n = 6'($urandom_range(1, 32));
      run_xfer(5'($urandom), n, 0, int'(n) + 3, 1'b0);
    end
    for (int r = 0; r < 4; r++)
      run_xfer(5'($urandom), 6'($urandom_range(1, 32)), 2, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end
endmodule
